clk_div_detect: RTL and testbench

CLK_DIV_DETECT -- requirements
Module: clk_div_detect

---
 rtl/clk_div_detect.sv | 172 +++++++++++++++++
 tb/tb_clk_div_detect.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_detect.sv
// Measures a divided clock (div_in, sampled as data): rise pulses, period, high time, lock and stall.
// Optional CLK_DIV_DETECT_SYNC_EN adds a two-flop synchronizer in front of the edge detector.
module clk_div_detect #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             edge_rise,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             stall,
  output logic [1:0]       state_dbg
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  logic s_in;     // value loaded into s on this edge
  logic s_in_ok;  // s_in is a real sample of div_in, not a reset leftover

`ifdef CLK_DIV_DETECT_SYNC_EN
  logic sync1_q, sync1_d;
  logic fill_q, fill_d;

  always_comb begin
    sync1_d = div_in;
    fill_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      fill_q  <= fill_d;
    end
  end

  assign s_in    = sync1_q;
  assign s_in_ok = fill_q;
`else
  assign s_in    = div_in;
  assign s_in_ok = 1'b1;
`endif

  logic             s_q, s_d;
  logic             s_dly_q, s_dly_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [MW-1:0]    match_q, match_d;
  logic             stall_q, stall_d;
  state_t           state_q, state_d;

  logic             rise, fall, timeout, same;
  logic [CNT_W-1:0] new_per;
  logic [MW-1:0]    match_inc;

  always_comb begin
    // armed blocks a false rise when div_in is already high as reset releases
    rise      = s_q & ~s_dly_q & armed_q;
    fall      = ~s_q & s_dly_q;
    timeout   = (cnt_q == MAX) && (state_q != IDLE);
    new_per   = cnt_q + 1'b1;
    same      = (new_per == period_q);
    match_inc = match_q + 1'b1;

    s_d         = s_in;
    s_dly_d     = s_q;
    armed_d     = armed_q | (s_in_ok & ~s_in);
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    match_d     = match_q;
    stall_d     = stall_q;
    state_d     = state_q;

    if (rise)              cnt_d = '0;
    else if (cnt_q != MAX) cnt_d = cnt_q + 1'b1;

    if (rise)                          hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (s_q && (hcnt_q != MAX))   hcnt_d = hcnt_q + 1'b1;

    if (fall) high_time_d = hcnt_q;

    if (timeout) begin
      // a coincident rise restarts measurement as a first rise
      stall_d     = 1'b1;
      period_d    = '0;
      high_time_d = '0;
      match_d     = '0;
      state_d     = rise ? FIRST : IDLE;
    end else if (rise) begin
      stall_d = 1'b0;
      case (state_q)
        IDLE: state_d = FIRST;
        FIRST: begin
          state_d  = TRACK;
          period_d = new_per;
          match_d  = '0;
        end
        TRACK: begin
          period_d = new_per;
          if (!same) begin
            match_d = '0;
          end else if (match_inc == MW'(LOCK_CNT)) begin
            match_d = match_inc;
            state_d = LOCKED;
          end else begin
            match_d = match_inc;
          end
        end
        LOCKED: begin
          period_d = new_per;
          if (!same) begin
            match_d = '0;
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q         <= 1'b0;
      s_dly_q     <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      match_q     <= '0;
      stall_q     <= 1'b0;
      state_q     <= IDLE;
    end else begin
      s_q         <= s_d;
      s_dly_q     <= s_dly_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      match_q     <= match_d;
      stall_q     <= stall_d;
      state_q     <= state_d;
    end
  end

  assign edge_rise = rise;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign locked    = (state_q == LOCKED);
  assign stall     = stall_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_div_detect.sv
// Bench for clk_div_detect: pulse-train driver, rise-ordered expected queue, summary report.
// Edge latency expectation follows CLK_DIV_DETECT_SYNC_EN.
module tb_clk_div_detect;
  localparam int CNT_W = 8;
  localparam int EW    = 2 * CNT_W + 3;
`ifdef CLK_DIV_DETECT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             div_in = 1'b0;
  logic             edge_rise;
  logic [CNT_W-1:0] period, high_time;
  logic             locked, stall;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int prev_h_v = 0;
  bit ht_chk   = 1'b1;

  logic [EW-1:0] exp_q[$];
  int            drv_q[$];

  clk_div_detect #(.CNT_W(CNT_W), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .edge_rise(edge_rise),
    .period(period), .high_time(high_time), .locked(locked),
    .stall(stall), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int per, input int ht, input bit lk, input bit st);
    exp_q.push_back({ht_chk, st, lk, CNT_W'(ht), CNT_W'(per)});
    drv_q.push_back(cyc);
  endtask

  // one div_in pulse: h cycles high then l cycles low; expectation is for its rise
  task automatic pulse(input int h, input int l, input int per, input bit lk, input bit st);
    @(negedge clk);
    div_in = 1'b1;
    push_exp(per, prev_h_v, lk, st);
    prev_h_v = h;
    repeat (h) @(negedge clk);
    div_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_rise"}, edge_rise, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    prev_h_v = 0;
  endtask

  // scoreboard: compare each observed rise against the oldest expectation
  initial begin
    logic [EW-1:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (rst && edge_rise) begin
        if (exp_q.size() == 0) begin
          check("unexp_rise", edge_rise, 0);
        end else begin
          e = exp_q.pop_front();
          d = drv_q.pop_front();
          check("rise_lat", cyc - d, LAT);
          @(posedge clk);
          #1;
          check("period", period, e[CNT_W-1:0]);
          check("locked", locked, e[2*CNT_W]);
          check("stall", stall, e[2*CNT_W+1]);
          if (e[2*CNT_W+2]) check("high_time", high_time, e[2*CNT_W-1:CNT_W]);
        end
      end
    end
  end

  initial begin
    int h, l;
    rst = 1'b0;
    div_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("init");
    @(negedge clk);
    rst = 1'b1;

    // constant input after reset never stalls
    repeat (300) @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_state", state_dbg, 0);

    // clk/8, 4 high 4 low: period after 2nd rise, lock at 6th
    for (int i = 1; i <= 8; i++) pulse(4, 4, (i == 1) ? 0 : 8, i >= 6, 1'b0);

    // one 12-cycle period drops lock; lock returns 5 rises later
    pulse(6, 6, 8, 1'b1, 1'b0);
    pulse(4, 4, 12, 1'b0, 1'b0);
    for (int j = 1; j <= 5; j++) pulse(4, 4, 8, j == 5, 1'b0);

    // rise coincident with cnt==MAX: timeout plus first rise
    pulse(4, 252, 8, 1'b1, 1'b0);
    prev_h_v = 0;
    pulse(4, 4, 0, 1'b0, 1'b1);
    for (int j = 1; j <= 5; j++) pulse(4, 4, 8, j == 5, 1'b0);

    // timeout with div_in held low
    pulse(4, 200, 8, 1'b1, 1'b0);
    check("pre_to_stall", stall, 0);
    check("pre_to_locked", locked, 1);
    repeat (100) @(negedge clk);
    check("to_stall", stall, 1);
    check("to_locked", locked, 0);
    check("to_period", period, 0);
    check("to_high", high_time, 0);
    check("to_state", state_dbg, 0);
    prev_h_v = 0;
    pulse(4, 4, 0, 1'b0, 1'b0);
    pulse(4, 4, 8, 1'b0, 1'b0);
    for (int j = 1; j <= 4; j++) pulse(4, 4, 8, j == 4, 1'b0);

    // one-cycle reset mid-lock with div_in high across release
    @(negedge clk);
    div_in = 1'b1;
    push_exp(8, 4, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("held_high_rise", edge_rise, 0);
    check("held_high_state", state_dbg, 0);
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    ht_chk = 1'b0;
    prev_h_v = 0;
    pulse(4, 4, 0, 1'b0, 1'b0);
    ht_chk = 1'b1;
    pulse(4, 4, 8, 1'b0, 1'b0);

    // fastest input: 1 high, 1 low
    do_reset();
    for (int i = 1; i <= 8; i++) pulse(1, 1, (i == 1) ? 0 : 2, i >= 6, 1'b0);

    // random stable period: equal first rise keeps lock, then relock at 6th
    h = $urandom_range(7, 2);
    l = $urandom_range(7, 2);
    for (int k = 1; k <= 7; k++) pulse(h, l, (k == 1) ? 2 : h + l, (k == 1) || (k >= 6), 1'b0);

    repeat (20) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
